mode_ctrl: RTL and testbench

MODE_CTRL -- requirements
Module: mode_ctrl

---
 rtl/mode_ctrl.sv | 122 ++++++++++++
 tb/tb_mode_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mode_ctrl.sv
// Mode/field controller for a clock with alarm: steps through show and set
// states, issues one-clk increment strobes, and falls back to SHOW_T on inactivity.
module mode_ctrl #(
  parameter int TIMEOUT_S = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_inc,
  output logic       sel_toa,
  output logic       sel_moh,
  output logic       set_en,
  output logic       inc_t_h,
  output logic       inc_t_m,
  output logic       inc_t_s,
  output logic       inc_a_h,
  output logic       inc_a_m,
  output logic       inc_a_s,
  output logic       blink,
  output logic [2:0] mode_state
);

  typedef enum logic [2:0] {
    SHOW_T = 3'd0,
    SHOW_A = 3'd1,
    SET_TH = 3'd2,
    SET_TM = 3'd3,
    SET_TS = 3'd4,
    SET_AH = 3'd5,
    SET_AM = 3'd6,
    SET_AS = 3'd7
  } state_e;

  localparam logic [5:0] TMO_LIM = 6'(TIMEOUT_S);

  state_e     state_q, state_d;
  logic       view_q, view_d;
  logic [5:0] tmo_q, tmo_d;
  logic       blink_q, blink_d;
  logic [5:0] inc_q, inc_d;   // {t_h, t_m, t_s, a_h, a_m, a_s}

  logic is_show_q, is_show_d, btn_any;

  assign is_show_q = (state_q == SHOW_T) || (state_q == SHOW_A);
  assign is_show_d = (state_d == SHOW_T) || (state_d == SHOW_A);
  assign btn_any   = btn_mode | btn_next | btn_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SHOW_T;
      view_q  <= 1'b1;
      tmo_q   <= '0;
      blink_q <= 1'b0;
      inc_q   <= '0;
    end else begin
      state_q <= state_d;
      view_q  <= view_d;
      tmo_q   <= tmo_d;
      blink_q <= blink_d;
      inc_q   <= inc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    view_d  = view_q;
    inc_d   = '0;

    // Button priority: mode, then next, then inc; lower ones are dropped.
    if (btn_mode) begin
      unique case (state_q)
        SHOW_T:                 state_d = SHOW_A;
        SHOW_A:                 state_d = SET_TH;
        SET_TH, SET_TM, SET_TS: state_d = SET_AH;
        default:                state_d = SHOW_T;
      endcase
    end else if (btn_next) begin
      unique case (state_q)
        SHOW_T, SHOW_A: view_d  = ~view_q;
        SET_TH:         state_d = SET_TM;
        SET_TM:         state_d = SET_TS;
        SET_TS:         state_d = SHOW_T;
        SET_AH:         state_d = SET_AM;
        SET_AM:         state_d = SET_AS;
        default:        state_d = SHOW_A;
      endcase
    end else if (btn_inc) begin
      unique case (state_q)
        SET_TH:  inc_d = 6'b100000;
        SET_TM:  inc_d = 6'b010000;
        SET_TS:  inc_d = 6'b001000;
        SET_AH:  inc_d = 6'b000100;
        SET_AM:  inc_d = 6'b000010;
        SET_AS:  inc_d = 6'b000001;
        default: inc_d = 6'b000000;
      endcase
    end else if (!is_show_q && tmo_q == TMO_LIM) begin
      state_d = SHOW_T;
    end

    // A tick coincident with a button press is not counted.
    if (is_show_q || is_show_d || btn_any) tmo_d = '0;
    else if (tick_1hz)                    tmo_d = tmo_q + 6'd1;
    else                                  tmo_d = tmo_q;

    if (is_show_d || state_d != state_q) blink_d = 1'b0;
    else if (tick_1hz)                   blink_d = ~blink_q;
    else                                 blink_d = blink_q;
  end

  assign mode_state = state_q;
  assign set_en     = ~is_show_q;
  assign sel_toa    = (state_q == SHOW_A) || (state_q == SET_AH) ||
                      (state_q == SET_AM) || (state_q == SET_AS);
  assign sel_moh    = is_show_q ? view_q
                    : !((state_q == SET_TS) || (state_q == SET_AS));
  assign blink      = blink_q;
  assign {inc_t_h, inc_t_m, inc_t_s, inc_a_h, inc_a_m, inc_a_s} = inc_q;

endmodule

// File: tb/tb_mode_ctrl.sv
// Directed vector bench for mode_ctrl, built with a 3-second timeout.
module tb_mode_ctrl;

  logic clk = 1'b0;
  logic rst_n, tick_1hz, btn_mode, btn_next, btn_inc;
  logic sel_toa, sel_moh, set_en, blink;
  logic inc_t_h, inc_t_m, inc_t_s, inc_a_h, inc_a_m, inc_a_s;
  logic [2:0] mode_state;

  int checks = 0;
  int errors = 0;

  mode_ctrl #(.TIMEOUT_S(3)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
    .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc),
    .sel_toa(sel_toa), .sel_moh(sel_moh), .set_en(set_en),
    .inc_t_h(inc_t_h), .inc_t_m(inc_t_m), .inc_t_s(inc_t_s),
    .inc_a_h(inc_a_h), .inc_a_m(inc_a_m), .inc_a_s(inc_a_s),
    .blink(blink), .mode_state(mode_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       m, n, i, t;
    logic [2:0] st;
    logic       toa, moh, se;
    logic [5:0] inc;
    logic       bl;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [3:0] mnit, input logic [2:0] st,
                     input logic toa, input logic moh, input logic se,
                     input logic [5:0] inc, input logic bl);
    vec_t v;
    {v.m, v.n, v.i, v.t} = mnit;
    v.st = st; v.toa = toa; v.moh = moh; v.se = se; v.inc = inc; v.bl = bl;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [2:0] st, input logic toa,
                         input logic moh, input logic se, input logic [5:0] inc,
                         input logic bl);
    chk("mode_state", idx, 8'(mode_state), 8'(st));
    chk("sel_toa",    idx, 8'(sel_toa),    8'(toa));
    chk("sel_moh",    idx, 8'(sel_moh),    8'(moh));
    chk("set_en",     idx, 8'(set_en),     8'(se));
    chk("inc",        idx, 8'({inc_t_h, inc_t_m, inc_t_s, inc_a_h, inc_a_m, inc_a_s}), 8'(inc));
    chk("blink",      idx, 8'(blink),      8'(bl));
  endtask

  localparam logic [3:0] M = 4'b1000, N = 4'b0100, I = 4'b0010, T = 4'b0001, Z = 4'b0000;

  initial begin
    rst_n = 1'b0; tick_1hz = 0; btn_mode = 0; btn_next = 0; btn_inc = 0;

    // mode cycle 0->1->2->5->0, inc ignored in show states
    add(M, 1, 1, 1, 0, 0, 0); add(M, 2, 0, 1, 1, 0, 0);
    add(M, 5, 1, 1, 1, 0, 0); add(M, 0, 0, 1, 0, 0, 0);
    add(I, 0, 0, 1, 0, 0, 0); add(M, 1, 1, 1, 0, 0, 0);
    add(I, 1, 1, 1, 0, 0, 0);
    // time edit
    add(M, 2, 0, 1, 1, 0, 0); add(I, 2, 0, 1, 1, 6'b100000, 0);
    add(N, 3, 0, 1, 1, 0, 0); add(I, 3, 0, 1, 1, 6'b010000, 0);
    add(Z, 3, 0, 1, 1, 0, 0); add(I, 3, 0, 1, 1, 6'b010000, 0);
    add(N, 4, 0, 0, 1, 0, 0); add(I, 4, 0, 0, 1, 6'b001000, 0);
    add(N, 0, 0, 1, 0, 0, 0); add(Z, 0, 0, 1, 0, 0, 0);
    // priority in SET_TM
    add(M, 1, 1, 1, 0, 0, 0); add(M, 2, 0, 1, 1, 0, 0);
    add(N, 3, 0, 1, 1, 0, 0); add(M|N|I, 5, 1, 1, 1, 0, 0);
    add(Z, 5, 1, 1, 1, 0, 0); add(M, 0, 0, 1, 0, 0, 0);
    // timeout in SET_AM
    add(M, 1, 1, 1, 0, 0, 0); add(M, 2, 0, 1, 1, 0, 0);
    add(M, 5, 1, 1, 1, 0, 0); add(N, 6, 1, 1, 1, 0, 0);
    add(T, 6, 1, 1, 1, 0, 1); add(T, 6, 1, 1, 1, 0, 0);
    add(I|T, 6, 1, 1, 1, 6'b000010, 1);
    add(T, 6, 1, 1, 1, 0, 0); add(T, 6, 1, 1, 1, 0, 1);
    add(T, 6, 1, 1, 1, 0, 0); add(Z, 0, 0, 1, 0, 0, 0);
    // view flag and blink
    add(N, 0, 0, 0, 0, 0, 0); add(M, 1, 1, 0, 0, 0, 0);
    add(M, 2, 0, 1, 1, 0, 0); add(T, 2, 0, 1, 1, 0, 1);
    add(T, 2, 0, 1, 1, 0, 0); add(M, 5, 1, 1, 1, 0, 0);
    add(M, 0, 0, 0, 0, 0, 0); add(M, 1, 1, 0, 0, 0, 0);
    add(N, 1, 1, 1, 0, 0, 0);
    // walk to SET_AS
    add(M, 2, 0, 1, 1, 0, 0); add(M, 5, 1, 1, 1, 0, 0);
    add(N, 6, 1, 1, 1, 0, 0); add(N, 7, 1, 0, 1, 0, 0);

    repeat (2) @(posedge clk);
    #1 chk_all(-1, 0, 0, 1, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;

    for (int k = 0; k < vq.size(); k++) begin
      @(negedge clk);
      {btn_mode, btn_next, btn_inc, tick_1hz} = {vq[k].m, vq[k].n, vq[k].i, vq[k].t};
      @(posedge clk);
      #1 chk_all(k, vq[k].st, vq[k].toa, vq[k].moh, vq[k].se, vq[k].inc, vq[k].bl);
    end

    // async reset mid-edit in SET_AS with a strobe pending and btn_inc held
    @(negedge clk);
    {btn_mode, btn_next, btn_inc, tick_1hz} = I;
    @(posedge clk);
    #1 chk_all(100, 7, 1, 0, 1, 6'b000001, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all(101, 0, 0, 1, 0, 0, 0);
    @(posedge clk);
    #1 chk_all(102, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    btn_inc = 1'b0; rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 chk_all(103 + k, 0, 0, 1, 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
